// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and write-back signals of the
// load/store unit. The slave modport is the unit's view; the master modport
// is the view of whatever drives requests and models the data memory.
interface load_store_unit_if;
   // execute-stage request
   logic        req_valid;
   logic        req_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   // data-memory port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   // completion / write-back
   logic        done;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;

   modport slave (
      input  req_valid, is_store, funct3, addr, store_data, rd_in,
      input  mem_rdata, mem_ack,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output done, wb_we, wb_rd, wb_data, err
   );

   modport master (
      output req_valid, is_store, funct3, addr, store_data, rd_in,
      output mem_rdata, mem_ack,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  done, wb_we, wb_rd, wb_data, err
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store unit with a three-state FSM
// (IDLE -> ACCESS -> DONE). Byte enables and lane-replicated store data are
// computed once when the request is accepted and held for the whole access;
// load data is lane-extracted and sign/zero-extended on the ack cycle.
// An ACCESS that sees no ack for MAX_WAIT cycles completes with err=1.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to make misaligned halfword
// and word accesses complete immediately with err=1 and no memory access.
// Without it the offending low address bits are treated as zero.
module load_store_unit #(
   parameter int MAX_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

   // ------------------------------------------------------------------
   // helper functions
   // ------------------------------------------------------------------

   // Only B, H, W, BU, HU are valid width codes.
   function automatic logic illegal_f3(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
         default:                                illegal_f3 = 1'b1;
      endcase
   endfunction

   // Force the offset bits that a halfword/word access cannot use to zero.
   // In the trapping build misaligned requests never get this far, so the
   // masking is a no-op there.
   function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   eff_offset = off;
         2'b01:   eff_offset = {off[1], 1'b0};
         2'b10:   eff_offset = 2'b00;
         default: eff_offset = 2'b00;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   // Halfword on an odd byte, or word not on a word boundary.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off != 2'b00);
         default: misaligned = 1'b0;
      endcase
   endfunction
`endif

   // Byte enables for the selected width at the (effective) byte offset.
   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   byte_en = 4'b0001 << off;
         2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

   // Replicate the low byte/halfword of store data into every lane.
   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
      case (f3[1:0])
         2'b00:   lane_wdata = {4{data[7:0]}};
         2'b01:   lane_wdata = {2{data[15:0]}};
         2'b10:   lane_wdata = data;
         default: lane_wdata = 32'h0000_0000;
      endcase
   endfunction

   // Select the addressed lane of the read word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      case (off)
         2'b00:   lane_b = rdata[7:0];
         2'b01:   lane_b = rdata[15:8];
         2'b10:   lane_b = rdata[23:16];
         2'b11:   lane_b = rdata[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  load_extract = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_extract = {24'h00_0000, lane_b};
         3'b001:  load_extract = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_extract = {16'h0000, lane_h};
         3'b010:  load_extract = rdata;
         default: load_extract = 32'h0000_0000;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // state
   // ------------------------------------------------------------------
   state_e      state_q,     state_d;
   logic [7:0]  wait_cnt_q,  wait_cnt_d;
   logic        is_store_q,  is_store_d;
   logic [2:0]  funct3_q,    funct3_d;
   logic [1:0]  off_q,       off_d;
   logic [4:0]  rd_q,        rd_d;
   logic        req_ready_q, req_ready_d;
   logic        mem_req_q,   mem_req_d;
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [3:0]  mem_be_q,    mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_q,      done_d;
   logic        wb_we_q,     wb_we_d;
   logic [4:0]  wb_rd_q,     wb_rd_d;
   logic [31:0] wb_data_q,   wb_data_d;
   logic        err_q,       err_d;

   logic        trap_s;
   logic [1:0]  req_off_s;
   logic [8:0]  wait_now_s;
   logic        timeout_s;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_s = misaligned(bus.funct3, bus.addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   assign req_off_s  = eff_offset(bus.funct3, bus.addr[1:0]);
   // Number of ACCESS cycles elapsed including the current one.
   assign wait_now_s = {1'b0, wait_cnt_q} + 9'd1;
   assign timeout_s  = (wait_now_s >= WAIT_LIMIT);

   // Next-state and next-output logic for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      is_store_d  = is_store_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      rd_d        = rd_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      wb_we_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               is_store_d = bus.is_store;
               funct3_d   = bus.funct3;
               off_d      = req_off_s;
               rd_d       = bus.rd_in;
               if (illegal_f3(bus.funct3) || trap_s) begin
                  // rejected without touching memory
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  wb_we_d = 1'b0;
                  wb_rd_d = bus.rd_in;
               end else begin
                  state_d     = S_ACCESS;
                  wait_cnt_d  = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.is_store;
                  mem_addr_d  = {bus.addr[31:2], 2'b00};
                  mem_be_d    = byte_en(bus.funct3, req_off_s);
                  mem_wdata_d = lane_wdata(bus.funct3, bus.store_data);
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ACCESS: begin
            if (bus.mem_ack) begin
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
               done_d    = 1'b1;
               err_d     = 1'b0;
               wb_we_d   = !is_store_q;
               wb_rd_d   = rd_q;
               if (!is_store_q) begin
                  wb_data_d = load_extract(funct3_q, off_q, bus.mem_rdata);
               end else begin
                  wb_data_d = wb_data_q;
               end
            end else if (timeout_s) begin
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
               done_d    = 1'b1;
               err_d     = 1'b1;
               wb_we_d   = 1'b0;
               wb_rd_d   = rd_q;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            mem_be_d  = 4'b0000;
         end
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 8'd0;
         is_store_q  <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         rd_q        <= 5'd0;
         req_ready_q <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
         done_q      <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'h0000_0000;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         is_store_q  <= is_store_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         req_ready_q <= req_ready_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         wb_we_q     <= wb_we_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.done      = done_q;
   assign bus.wb_we     = wb_we_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.err       = err_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255, meaning: ack-timeout limit in ACCESS cycles, legal range 1..255.
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port req_valid  input  1  execute stage presents a memory op.
REQ-005 Port req_ready  output  1  unit can accept a request.
REQ-006 Port is_store  input  1  1 = store, 0 = load.
REQ-007 Port funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port addr  input  32  effective address, i.e. the ALU ADD result.
REQ-009 Port store_data  input  32  rs2 value, data in low bits.
REQ-010 Port rd_in  input  5  destination register of the load.
REQ-011 Port mem_req  output  1  data-memory request.
REQ-012 Port mem_we  output  1  write enable.
REQ-013 Port mem_addr  output  32  word address, bits[1:0] always 00.
REQ-014 Port mem_be  output  4  byte enables.
REQ-015 Port mem_wdata  output  32  lane-replicated store data.
REQ-016 Port mem_rdata  input  32  read word, valid when mem_ack=1.
REQ-017 Port mem_ack  input  1  access complete.
REQ-018 Port done  output  1  one-cycle completion pulse.
REQ-019 Port wb_we  output  1  done for a load with err=0.
REQ-020 Port wb_rd  output  5  latched rd_in.
REQ-021 Port wb_data  output  32  extended load result.
REQ-022 Port err  output  1  valid with done: timeout, illegal funct3 or misalignment.

Function
REQ-023 FSM states IDLE, ACCESS, DONE; req_ready = 1 only in IDLE.
REQ-024 IDLE: on req_valid=1, latch is_store, funct3, addr, store_data, rd_in and go to ACCESS, or to DONE with err=1 for illegal funct3 (011, 110, 111) or misalignment per REQ-036.
REQ-025 ACCESS: mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held stable from the latched values until exit.
REQ-026 mem_be: B = 0001 shifted left by addr[1:0]; H = 0011 shifted left by addr[1] x 2; W = 1111; load and store both drive mem_be.
REQ-027 mem_wdata: B = byte replicated 4x; H = halfword replicated 2x; W = as-is.
REQ-028 Load extraction selects the lane by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-029 mem_ack=1 in ACCESS: capture wb_data (loads) and go to DONE with err=0; an ack on the first ACCESS cycle is legal (2-cycle request-to-done).
REQ-030 A wait counter is cleared on ACCESS entry and increments each ACCESS cycle without ack; ACCESS with count = MAX_WAIT and no ack goes to DONE with err=1 and mem_req=0.
REQ-031 An ack in the same cycle the count reaches MAX_WAIT is a success.
REQ-032 DONE lasts exactly one cycle with done=1, then IDLE; wb_we = !is_store & !err.
REQ-033 mem_ack outside ACCESS is ignored; wb_data, wb_rd and err hold until the next done.

Reset
REQ-034 rst=1 at a clock edge forces IDLE from any state, including mid-ACCESS, dropping mem_req the next cycle; a pending access is abandoned with no done.
REQ-035 Reset values: req_ready=1; mem_req, mem_we, done, wb_we, err = 0; mem_be = 0000; mem_addr, mem_wdata, wb_data = 0; wb_rd = 0; counter = 0.

Configuration
REQ-036 With LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=00 issues no memory access and goes IDLE->DONE with err=1.
REQ-037 Without LSU_MISALIGN_TRAP_EN: the offending low address bits are treated as zero (H clears addr[0], W clears addr[1:0]); the access proceeds and err is never set for misalignment.

Verification
REQ-038 SB addr=0x1003, data=0x000000A5, ack on the 1st ACCESS cycle -> mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, done at request+2, wb_we=0.
REQ-039 LB addr=0x2001, rdata=0x0000F000, ack after 3 cycles -> wb_data=0xFFFFFFF0, wb_we=1, wb_rd=rd_in; LBU on the same data -> 0x000000F0.
REQ-040 LH addr=0x0002, rdata=0x80017FFF -> wb_data=0xFFFF8001; LHU -> 0x00008001.
REQ-041 LW, no ack, MAX_WAIT=4 -> mem_req high for exactly 4 ACCESS cycles, done with err=1, wb_we=0; ack exactly on cycle 4 -> err=0.
REQ-042 LW addr=0x0006 -> macro defined: no mem_req, done the next cycle, err=1; macro undefined: mem_addr=0x0004, err=0.
REQ-043 rst asserted during the 2nd ACCESS cycle -> mem_req=0 the next cycle, no done, req_ready=1.
